// File: rtl/coin_pkg.sv
// Shared types and constants for the coin-slot payer: FSM states, strobe
// encodings and default coin values.
package coin_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEL,
      S_DRIVE,
      S_GAP,
      S_WAIT,
      S_FIN
   } state_t;

   localparam logic [1:0] COIN_NONE  = 2'b00;
   localparam logic [1:0] COIN_SMALL = 2'b01;
   localparam logic [1:0] COIN_LARGE = 2'b10;

   localparam int DEF_SMALL_VAL = 1;
   localparam int DEF_LARGE_VAL = 2;

endpackage

// File: rtl/coin_select.sv
// Greedy coin chooser: prefer a large coin while it fits, then small coins,
// and fall back to overpaying with a large coin before declaring exhaustion.
module coin_select #(
   parameter int AMT_W     = 4,
   parameter int CNT_W     = 4,
   parameter int LARGE_VAL = coin_pkg::DEF_LARGE_VAL
) (
   input  logic [AMT_W-1:0] rem,
   input  logic [CNT_W-1:0] stock_small,
   input  logic [CNT_W-1:0] stock_large,
   output logic             choose_large,
   output logic             choose_small,
   output logic             exhausted
);

   always_comb begin
      choose_large = 1'b0;
      choose_small = 1'b0;
      exhausted    = 1'b0;
      if (int'(rem) >= LARGE_VAL && stock_large != '0)
         choose_large = 1'b1;
      else if (stock_small != '0)
         choose_small = 1'b1;
      else if (stock_large != '0)
         choose_large = 1'b1;
      else
         exhausted = 1'b1;
   end

endmodule

// File: rtl/coin_feeder.sv
// Payer side of the coin-slot interface: pays AMOUNT from a finite stock one
// strobe at a time, then waits for the ticket and tallies returned change.
module coin_feeder
   import coin_pkg::*;
#(
   parameter int SMALL_VAL = DEF_SMALL_VAL,
   parameter int LARGE_VAL = DEF_LARGE_VAL,
   parameter int AMT_W     = 4,
   parameter int CNT_W     = 4,
   parameter int GAP       = 1,
   parameter int TIMEOUT   = 8
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             START,
   input  logic [AMT_W-1:0] AMOUNT,
   input  logic [CNT_W-1:0] AVAIL_SMALL,
   input  logic [CNT_W-1:0] AVAIL_LARGE,
   output logic             M0,
   output logic             M1,
   input  logic             T,
   input  logic             C0,
   input  logic             C1,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERR,
   output logic [CNT_W-1:0] SMALL_USED,
   output logic [CNT_W-1:0] LARGE_USED,
   output logic [AMT_W:0]   CHANGE
);

   localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t              state;
   logic [AMT_W-1:0]    rem;
   logic [CNT_W-1:0]    stk_small;
   logic [CNT_W-1:0]    stk_large;
   logic [GAP_W-1:0]    gap_cnt;
   logic [WAIT_W-1:0]   wait_cnt;

   logic                sel_large;
   logic                sel_small;
   logic                sel_exhausted;
   logic [AMT_W-1:0]    coin_val;
   logic [AMT_W-1:0]    rem_after;
   logic [AMT_W+1:0]    change_sum;
   logic [AMT_W:0]      change_next;

   coin_select #(
      .AMT_W     (AMT_W),
      .CNT_W     (CNT_W),
      .LARGE_VAL (LARGE_VAL)
   ) u_select (
      .rem          (rem),
      .stock_small  (stk_small),
      .stock_large  (stk_large),
      .choose_large (sel_large),
      .choose_small (sel_small),
      .exhausted    (sel_exhausted)
   );

   // In DRIVE the registered M0 still identifies which coin is going out.
   always_comb begin
      coin_val  = M0 ? AMT_W'(LARGE_VAL) : AMT_W'(SMALL_VAL);
      rem_after = (rem > coin_val) ? rem - coin_val : '0;
   end

   always_comb begin
      change_sum  = {1'b0, CHANGE}
                  + (C0 ? (AMT_W+2)'(SMALL_VAL) : '0)
                  + (C1 ? (AMT_W+2)'(LARGE_VAL) : '0);
      change_next = change_sum[AMT_W+1] ? '1 : change_sum[AMT_W:0];
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state      <= S_IDLE;
         rem        <= '0;
         stk_small  <= '0;
         stk_large  <= '0;
         gap_cnt    <= '0;
         wait_cnt   <= '0;
         M0         <= 1'b0;
         M1         <= 1'b0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
         ERR        <= 1'b0;
         SMALL_USED <= '0;
         LARGE_USED <= '0;
         CHANGE     <= '0;
      end else begin
         {M0, M1} <= COIN_NONE;
         DONE     <= 1'b0;
         ERR      <= 1'b0;
         if (state != S_IDLE)
            CHANGE <= change_next;

         case (state)
            S_IDLE: begin
               if (START) begin
                  rem        <= AMOUNT;
                  stk_small  <= AVAIL_SMALL;
                  stk_large  <= AVAIL_LARGE;
                  SMALL_USED <= '0;
                  LARGE_USED <= '0;
                  CHANGE     <= '0;
                  wait_cnt   <= '0;
                  BUSY       <= 1'b1;
                  state      <= (AMOUNT == '0) ? S_WAIT : S_SEL;
               end
            end

            S_FIN: begin
               BUSY  <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               // A coin whose strobe is already out counts even if T lands on it.
               if (state == S_DRIVE) begin
                  rem <= rem_after;
                  if (M0) begin
                     stk_large  <= stk_large - CNT_W'(1);
                     LARGE_USED <= LARGE_USED + CNT_W'(1);
                  end else begin
                     stk_small  <= stk_small - CNT_W'(1);
                     SMALL_USED <= SMALL_USED + CNT_W'(1);
                  end
               end

               if (T) begin
                  DONE  <= 1'b1;
                  state <= S_FIN;
               end else begin
                  case (state)
                     S_SEL: begin
                        if (sel_exhausted) begin
                           ERR   <= 1'b1;
                           BUSY  <= 1'b0;
                           state <= S_IDLE;
                        end else begin
                           {M0, M1} <= sel_large ? COIN_LARGE :
                                       (sel_small ? COIN_SMALL : COIN_NONE);
                           state    <= S_DRIVE;
                        end
                     end
                     S_DRIVE: begin
                        gap_cnt  <= '0;
                        wait_cnt <= '0;
                        if (GAP > 0)
                           state <= S_GAP;
                        else if (rem_after != '0)
                           state <= S_SEL;
                        else
                           state <= S_WAIT;
                     end
                     S_GAP: begin
                        if (gap_cnt == GAP_W'(GAP - 1)) begin
                           wait_cnt <= '0;
                           state    <= (rem != '0) ? S_SEL : S_WAIT;
                        end else begin
                           gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                     end
                     S_WAIT: begin
                        if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                           ERR   <= 1'b1;
                           BUSY  <= 1'b0;
                           state <= S_IDLE;
                        end else begin
                           wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                     end
                     default: begin
                        BUSY  <= 1'b0;
                        state <= S_IDLE;
                     end
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_coin_feeder.sv
// Bench for coin_feeder: directed scenarios plus randomized transactions,
// each compared against a greedy payment model built from plain arithmetic.
module tb_coin_feeder;

   localparam int AMT_W     = 4;
   localparam int CNT_W     = 4;
   localparam int GAP       = 1;
   localparam int TIMEOUT   = 8;
   localparam int SMALL_VAL = 1;
   localparam int LARGE_VAL = 2;
   localparam int PERIOD    = 2 + GAP;
   localparam int CHG_MAX   = (1 << (AMT_W + 1)) - 1;
   localparam int LIMIT     = 120;

   logic             CLK = 1'b0;
   logic             RESET_N;
   logic             START;
   logic [AMT_W-1:0] AMOUNT;
   logic [CNT_W-1:0] AVAIL_SMALL;
   logic [CNT_W-1:0] AVAIL_LARGE;
   logic             M0;
   logic             M1;
   logic             T;
   logic             C0;
   logic             C1;
   logic             BUSY;
   logic             DONE;
   logic             ERR;
   logic [CNT_W-1:0] SMALL_USED;
   logic [CNT_W-1:0] LARGE_USED;
   logic [AMT_W:0]   CHANGE;

   coin_feeder #(
      .SMALL_VAL (SMALL_VAL),
      .LARGE_VAL (LARGE_VAL),
      .AMT_W     (AMT_W),
      .CNT_W     (CNT_W),
      .GAP       (GAP),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .START       (START),
      .AMOUNT      (AMOUNT),
      .AVAIL_SMALL (AVAIL_SMALL),
      .AVAIL_LARGE (AVAIL_LARGE),
      .M0          (M0),
      .M1          (M1),
      .T           (T),
      .C0          (C0),
      .C1          (C1),
      .BUSY        (BUSY),
      .DONE        (DONE),
      .ERR         (ERR),
      .SMALL_USED  (SMALL_USED),
      .LARGE_USED  (LARGE_USED),
      .CHANGE      (CHANGE)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Strobes are recorded as cycle*4 + {M0,M1}, cycle 0 being the first
   // cycle after the edge that samples START.
   int exp_strobes[$];
   int obs_strobes[$];
   int exp_done, exp_err, exp_small, exp_large, exp_change;
   int obs_done, obs_err, saw_both, busy0, busy_after, pulse_after;
   int t_cycle, drive_end;
   bit c0_sched [LIMIT];
   bit c1_sched [LIMIT];

   task automatic checkOutput(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic modelTxn(input int amount, input int avs, input int avl,
                           input int tc, input bit use_c, input bit c0t, input bit c1t);
      int rem, s, l, n, end_cyc, cyc, chg;
      bit exhausted;
      int coins[$];
      rem = amount; s = avs; l = avl; exhausted = 0;
      while (rem > 0) begin
         if (rem >= LARGE_VAL && l > 0) begin
            coins.push_back(2); l--; rem -= LARGE_VAL;
         end else if (s > 0) begin
            coins.push_back(1); s--; rem -= SMALL_VAL;
         end else if (l > 0) begin
            coins.push_back(2); l--; rem -= LARGE_VAL;
         end else begin
            exhausted = 1;
            break;
         end
         if (rem < 0) rem = 0;
      end
      n       = coins.size();
      end_cyc = exhausted ? n * PERIOD + 1 : n * PERIOD + TIMEOUT;
      t_cycle = (tc >= 0) ? tc % end_cyc : -1;

      exp_strobes.delete();
      exp_small = 0;
      exp_large = 0;
      for (int k = 0; k < n; k++) begin
         cyc = 1 + k * PERIOD;
         if (t_cycle < 0 || cyc <= t_cycle) begin
            exp_strobes.push_back(cyc * 4 + coins[k]);
            if (coins[k] == 2) exp_large++;
            else exp_small++;
         end
      end

      if (t_cycle >= 0) begin
         exp_done  = t_cycle + 1;
         exp_err   = -1;
         drive_end = t_cycle + 1;
      end else begin
         exp_done  = -1;
         exp_err   = end_cyc;
         drive_end = end_cyc;
      end

      chg = 0;
      for (int c = 0; c < LIMIT; c++) begin
         c0_sched[c] = use_c ? 1'($urandom_range(0, 1)) : 1'b0;
         c1_sched[c] = use_c ? 1'($urandom_range(0, 1)) : 1'b0;
         if (c == t_cycle) begin
            c0_sched[c] = c0t;
            c1_sched[c] = c1t;
         end
         if (c < drive_end)
            chg += (c0_sched[c] ? SMALL_VAL : 0) + (c1_sched[c] ? LARGE_VAL : 0);
      end
      exp_change = (chg > CHG_MAX) ? CHG_MAX : chg;
   endtask

   task automatic applyStimulus(input int amount, input int avs, input int avl,
                                input int tc, input bit use_c, input bit c0t,
                                input bit c1t, input bit busy_start);
      modelTxn(amount, avs, avl, tc, use_c, c0t, c1t);
      obs_strobes.delete();
      obs_done = -1;
      obs_err  = -1;
      saw_both = 0;

      @(negedge CLK);
      START       = 1'b1;
      AMOUNT      = AMT_W'(amount);
      AVAIL_SMALL = CNT_W'(avs);
      AVAIL_LARGE = CNT_W'(avl);
      @(negedge CLK);
      busy0 = int'(BUSY);
      for (int c = 0; c < LIMIT; c++) begin
         if (c > 0) @(negedge CLK);
         START = 1'b0;
         T     = 1'b0;
         C0    = 1'b0;
         C1    = 1'b0;
         if ({M0, M1} == 2'b11) saw_both = 1;
         if ({M0, M1} != 2'b00) obs_strobes.push_back(c * 4 + int'({M0, M1}));
         if (DONE) obs_done = c;
         if (ERR)  obs_err  = c;
         if (DONE || ERR) break;
         T = (c == t_cycle);
         if (c < drive_end) begin
            C0 = c0_sched[c];
            C1 = c1_sched[c];
         end
         if (busy_start && c == 1) begin
            START       = 1'b1;
            AMOUNT      = AMT_W'(9);
            AVAIL_SMALL = CNT_W'(7);
            AVAIL_LARGE = CNT_W'(7);
         end
      end
      @(negedge CLK);
      START = 1'b0;
      T     = 1'b0;
      C0    = 1'b0;
      C1    = 1'b0;
      busy_after  = int'(BUSY);
      pulse_after = int'(DONE | ERR);
   endtask

   task automatic checkTransaction(input string name);
      checkOutput({name, " busy_start"}, busy0, 1);
      checkOutput({name, " strobe_count"}, obs_strobes.size(), exp_strobes.size());
      for (int i = 0; i < exp_strobes.size(); i++)
         checkOutput($sformatf("%s strobe%0d(cyc*4+code)", name, i),
                     (i < obs_strobes.size()) ? obs_strobes[i] : -1, exp_strobes[i]);
      checkOutput({name, " never_11"}, saw_both, 0);
      checkOutput({name, " done_cycle"}, obs_done, exp_done);
      checkOutput({name, " err_cycle"}, obs_err, exp_err);
      checkOutput({name, " small_used"}, int'(SMALL_USED), exp_small);
      checkOutput({name, " large_used"}, int'(LARGE_USED), exp_large);
      checkOutput({name, " change"}, int'(CHANGE), exp_change);
      checkOutput({name, " busy_end"}, busy_after, 0);
      checkOutput({name, " pulse_end"}, pulse_after, 0);
   endtask

   initial begin
      RESET_N     = 1'b0;
      START       = 1'b0;
      AMOUNT      = '0;
      AVAIL_SMALL = '0;
      AVAIL_LARGE = '0;
      T           = 1'b0;
      C0          = 1'b0;
      C1          = 1'b0;
      #12;
      checkOutput("reset strobes", int'({M0, M1}), 0);
      checkOutput("reset flags", int'({BUSY, DONE, ERR}), 0);
      checkOutput("reset counters", int'(SMALL_USED) + int'(LARGE_USED) + int'(CHANGE), 0);
      @(negedge CLK);
      RESET_N = 1'b1;

      $display("[TB] directed: pay 3, controller silent");
      applyStimulus(3, 2, 2, -1, 0, 0, 0, 0);
      checkTransaction("timeout");

      $display("[TB] directed: ticket with change on second strobe");
      applyStimulus(3, 2, 2, 4, 0, 1, 0, 0);
      checkTransaction("ticket");

      $display("[TB] directed: overpay with large coins only");
      applyStimulus(3, 0, 2, 4, 0, 1, 0, 0);
      checkTransaction("overpay");

      $display("[TB] directed: stock exhausted");
      applyStimulus(4, 1, 1, -1, 0, 0, 0, 0);
      checkTransaction("exhaust");

      $display("[TB] directed: zero amount, START while busy");
      applyStimulus(0, 3, 3, 2, 0, 0, 0, 1);
      checkTransaction("zero");

      $display("[TB] directed: reset during DRIVE");
      @(negedge CLK);
      START       = 1'b1;
      AMOUNT      = AMT_W'(3);
      AVAIL_SMALL = CNT_W'(2);
      AVAIL_LARGE = CNT_W'(2);
      @(negedge CLK);
      START = 1'b0;
      @(negedge CLK);
      checkOutput("pre-reset strobe", int'({M0, M1}), 2);
      #1 RESET_N = 1'b0;
      #1;
      checkOutput("mid reset strobes", int'({M0, M1}), 0);
      checkOutput("mid reset busy", int'(BUSY), 0);
      @(negedge CLK);
      RESET_N = 1'b1;
      applyStimulus(1, 2, 2, -1, 0, 0, 0, 0);
      checkTransaction("after_reset");

      $display("[TB] randomized transactions");
      for (int r = 0; r < 40; r++) begin
         int tc;
         tc = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 60));
         applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 4)),
                       int'($urandom_range(0, 4)), tc, 1'b1,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
         checkTransaction($sformatf("rand%0d", r));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
